// File: rtl/sync_fifo.sv
// Synchronous shift-register FIFO with first-word-fall-through read port.
// Entry 0 always holds the head word; a pop shifts every entry down by one.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);
   localparam int CNT_WIDTH = $clog2(DEPTH + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [CNT_WIDTH-1:0] count_reg;
   logic                 push_ok, pop_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_FULL);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && !full;
   assign rd_data = mem[0];

   always_ff @(posedge clk) begin
      if (srst)
         count_reg <= '0;
      else if (push_ok && !pop_ok)
         count_reg <= count_reg + CNT_WIDTH'(1);
      else if (pop_ok && !push_ok)
         count_reg <= count_reg - CNT_WIDTH'(1);
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [CNT_WIDTH-1:0] IDX = CNT_WIDTH'(gi);
      logic [WIDTH-1:0] upper;
      if (gi == DEPTH - 1) begin : g_top
         assign upper = wr_data;
      end else begin : g_mid
         assign upper = mem[gi+1];
      end
      // On a simultaneous push and pop the new word lands one slot lower.
      always_ff @(posedge clk) begin
         if (pop_ok)
            mem[gi] <= (push_ok && count_reg == IDX + CNT_WIDTH'(1)) ? wr_data : upper;
         else if (push_ok && count_reg == IDX)
            mem[gi] <= wr_data;
      end
   end
endmodule

// File: rtl/stream_width_down.sv
// Splits each upstream FWFT word into RATIO narrower chunks on a valid/ready
// stream; the next word is popped on the last accepted chunk so words run gap-free.
module stream_width_down #(
   parameter int IN_WIDTH  = 32,
   parameter int RATIO     = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [IN_WIDTH-1:0]       in_data,
   input  logic                      in_empty,
   output logic                      in_ena,
   output logic [IN_WIDTH/RATIO-1:0] out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last
);
   localparam int OUT_WIDTH = IN_WIDTH / RATIO;
   localparam int CNT_WIDTH = $clog2(RATIO);
   localparam logic [CNT_WIDTH-1:0] K_LAST = CNT_WIDTH'(RATIO - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state_reg, state_next;
   logic [CNT_WIDTH-1:0]  k_reg;
   logic [IN_WIDTH-1:0]   shift_reg, shift_next;
   logic                  accept, at_last, load;

   always_ff @(posedge clk) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (!in_empty) state_next = SHIFT;
         SHIFT: if (accept && at_last) state_next = in_empty ? IDLE : SHIFT;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state_reg == SHIFT);
      accept    = out_valid && out_ready;
      at_last   = (k_reg == K_LAST);
      out_last  = out_valid && at_last;
      // Pop only when the held word is gone (or about to be) and never in reset.
      load      = rst_n && !in_empty && (state_reg == IDLE || (accept && at_last));
      in_ena    = load;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         k_reg <= '0;
      else if (load)
         k_reg <= '0;
      else if (accept && !at_last)
         k_reg <= k_reg + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (load)
         shift_reg <= in_data;
      else if (accept && !at_last)
         shift_reg <= shift_next;
   end

   if (MSB_FIRST != 0) begin : g_msb
      assign out_data   = shift_reg[IN_WIDTH-1 -: OUT_WIDTH];
      assign shift_next = shift_reg << OUT_WIDTH;
   end else begin : g_lsb
      assign out_data   = shift_reg[OUT_WIDTH-1:0];
      assign shift_next = shift_reg >> OUT_WIDTH;
   end
endmodule

// File: tb/tb_stream_width_down.sv
// Bench: two width-down instances (LSB-first and MSB-first), each fed by its own
// FIFO from a shared push stream, checked against a chunk-queue model every cycle.
module tb_stream_width_down;
   localparam int W  = 32;
   localparam int R  = 4;
   localparam int OW = W / R;

   typedef struct {
      int           cyc;
      logic [OW-1:0] data;
      logic         last;
      logic         ena;
   } xfer_t;

   logic          clk = 0;
   logic          rst_n, fifo_rst, push, out_ready;
   logic [W-1:0]  wr_data;
   logic [W-1:0]  head [2];
   logic          in_empty [2], in_ena [2], full [2];
   logic [OW-1:0] out_data [2];
   logic          out_valid [2], out_last [2];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      sync_fifo #(.WIDTH(W), .DEPTH(4)) u_fifo (
         .clk(clk), .srst(fifo_rst), .push(push), .wr_data(wr_data),
         .pop(in_ena[gi]), .rd_data(head[gi]), .empty(in_empty[gi]), .full(full[gi]));
      stream_width_down #(.IN_WIDTH(W), .RATIO(R), .MSB_FIRST(gi)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_data(head[gi]), .in_empty(in_empty[gi]),
         .in_ena(in_ena[gi]), .out_data(out_data[gi]), .out_valid(out_valid[gi]),
         .out_ready(out_ready), .out_last(out_last[gi]));
   end

   int vec = 0, miscmp = 0, cyc = 0;
   // model: expected chunks (data, last) per instance
   logic [OW:0] exp_q [2][64];
   int exp_wr [2] = '{0, 0};
   int exp_rd [2] = '{0, 0};
   int acc    [2] = '{0, 0};
   xfer_t xlog [2][64];
   int xn [2]  = '{0, 0};
   int en_n [2] = '{0, 0};
   int en_cyc [2][64];
   logic          prev_stall [2] = '{1'b0, 1'b0};
   logic [OW-1:0] prev_data  [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vec++;
      if (act !== expv) begin
         miscmp++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (in_empty[i] === 1'b1 && in_ena[i] === 1'b1)
            chk($sformatf("ena_while_empty%0d", i), 1, 0);
         if (!rst_n) begin
            chk($sformatf("ena_in_reset%0d", i), in_ena[i], 0);
            while (acc[i] % R != 0) begin
               exp_rd[i]++;
               acc[i]++;
            end
            prev_stall[i] = 1'b0;
         end else begin
            if (out_last[i]) chk($sformatf("last_wo_valid%0d", i), out_valid[i], 1);
            if (prev_stall[i]) begin
               chk($sformatf("stall_valid%0d", i), out_valid[i], 1);
               chk($sformatf("stall_hold%0d", i), out_data[i], prev_data[i]);
            end
            if (out_valid[i] && in_ena[i])
               chk($sformatf("ena_in_shift%0d", i), out_ready && out_last[i], 1);
            if (out_valid[i] && out_ready) begin
               if (exp_rd[i] < exp_wr[i]) begin
                  chk($sformatf("data%0d", i), out_data[i], exp_q[i][exp_rd[i]][OW-1:0]);
                  chk($sformatf("last%0d", i), out_last[i], exp_q[i][exp_rd[i]][OW]);
               end else
                  chk($sformatf("extra_chunk%0d", i), 1, 0);
               exp_rd[i]++;
               acc[i]++;
               xlog[i][xn[i]] = '{cyc, out_data[i], out_last[i], in_ena[i]};
               xn[i]++;
            end
            if (in_ena[i]) begin
               en_cyc[i][en_n[i]] = cyc;
               en_n[i]++;
            end
            prev_stall[i] = out_valid[i] && !out_ready;
            prev_data[i]  = out_data[i];
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [W-1:0] w);
      push    = 1'b1;
      wr_data = w;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < R; j++) begin
            exp_q[i][exp_wr[i]] = {j == R - 1, (i == 1) ? w[OW*(R-1-j) +: OW] : w[OW*j +: OW]};
            exp_wr[i]++;
         end
      step(1);
      push = 1'b0;
   endtask

   task automatic check_log(input int i, input int base, input int n,
                            input logic [OW-1:0] e [8], input bit consec);
      chk($sformatf("count%0d", i), xn[i] - base, n);
      for (int j = 0; j < n; j++)
         if (base + j < xn[i]) begin
            chk($sformatf("lit_data%0d_%0d", i, j), xlog[i][base+j].data, e[j]);
            chk($sformatf("lit_last%0d_%0d", i, j), xlog[i][base+j].last, (j % R) == R - 1);
            if (consec && j > 0)
               chk($sformatf("gap%0d_%0d", i, j), xlog[i][base+j].cyc - xlog[i][base+j-1].cyc, 1);
         end
   endtask

   int b0, b1, e0, e1;
   bit seen;

   initial begin
      rst_n = 0; fifo_rst = 1; push = 0; out_ready = 1; wr_data = '0;
      step(3);
      fifo_rst = 0;
      // word queued while the block is still in reset: no pop allowed
      push_word(32'h44332211);
      step(3);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_valid%0d", i), out_valid[i], 0);
         chk($sformatf("rst_last%0d", i), out_last[i], 0);
         chk($sformatf("rst_ena%0d", i), in_ena[i], 0);
      end
      b0 = xn[0]; b1 = xn[1]; e0 = en_n[0]; e1 = en_n[1];
      rst_n = 1;
      step(8);
      check_log(0, b0, 4, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0, 8'h0, 8'h0}, 1);
      check_log(1, b1, 4, '{8'h44, 8'h33, 8'h22, 8'h11, 8'h0, 8'h0, 8'h0, 8'h0}, 1);
      chk("basic_pops0", en_n[0] - e0, 1);
      chk("basic_pops1", en_n[1] - e1, 1);
      if (en_n[0] > e0 && xn[0] > b0)
         chk("latency0", xlog[0][b0].cyc - en_cyc[0][e0], 1);

      // back-to-back words, no bubble
      b0 = xn[0]; b1 = xn[1]; e0 = en_n[0]; e1 = en_n[1];
      push_word(32'hA3A2A1A0);
      push_word(32'hB3B2B1B0);
      step(12);
      check_log(0, b0, 8, '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3}, 1);
      check_log(1, b1, 8, '{8'hA3, 8'hA2, 8'hA1, 8'hA0, 8'hB3, 8'hB2, 8'hB1, 8'hB0}, 1);
      chk("b2b_pops0", en_n[0] - e0, 2);
      chk("b2b_pops1", en_n[1] - e1, 2);
      if (xn[0] > b0 + 3) chk("b2b_ena_on_a3", xlog[0][b0+3].ena, 1);
      if (xn[1] > b1 + 3) chk("b2b_ena_on_a0", xlog[1][b1+3].ena, 1);

      // backpressure pattern 1,0,0,1,...
      b0 = xn[0]; b1 = xn[1]; e0 = en_n[0]; e1 = en_n[1];
      push_word(32'hC3C2C1C0);
      push_word(32'hD3D2D1D0);
      for (int k = 0; k < 40; k++) begin
         out_ready = (k % 4 == 0) || (k % 4 == 3);
         step(1);
      end
      out_ready = 1;
      step(2);
      check_log(0, b0, 8, '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD3}, 0);
      check_log(1, b1, 8, '{8'hC3, 8'hC2, 8'hC1, 8'hC0, 8'hD3, 8'hD2, 8'hD1, 8'hD0}, 0);
      chk("bp_pops0", en_n[0] - e0, 2);
      chk("bp_pops1", en_n[1] - e1, 2);

      // drain to empty and stay idle
      b0 = xn[0]; b1 = xn[1]; e0 = en_n[0];
      push_word(32'h0F0E0D0C);
      step(6);
      check_log(0, b0, 4, '{8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h0, 8'h0, 8'h0, 8'h0}, 1);
      check_log(1, b1, 4, '{8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0, 8'h0, 8'h0, 8'h0}, 1);
      for (int k = 0; k < 10; k++) begin
         chk("drain_valid0", out_valid[0], 0);
         chk("drain_ena0", in_ena[0], 0);
         step(1);
      end
      chk("drain_pops0", en_n[0] - e0, 1);

      // reset right after chunk 22 has transferred
      b0 = xn[0];
      push_word(32'h44332211);
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (xn[0] >= b0 + 2) seen = 1;
         else step(1);
      end
      chk("wait_chunk22", seen, 1);
      if (xn[0] >= b0 + 2) chk("pre_rst_chunk", xlog[0][b0+1].data, 8'h22);
      rst_n = 0; out_ready = 0;
      step(1);
      chk("midrst_valid0", out_valid[0], 0);
      chk("midrst_valid1", out_valid[1], 0);
      chk("midrst_last0", out_last[0], 0);
      rst_n = 1; out_ready = 1;
      step(2);
      b0 = xn[0]; b1 = xn[1];
      push_word(32'h0D0C0B0A);
      step(8);
      check_log(0, b0, 4, '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0, 8'h0, 8'h0, 8'h0}, 1);
      check_log(1, b1, 4, '{8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h0, 8'h0, 8'h0, 8'h0}, 1);

      chk("model_drained0", exp_rd[0], exp_wr[0]);
      chk("model_drained1", exp_rd[1], exp_wr[1]);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end
endmodule
